mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 36 +++
 rtl/mul_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: requester, response and multiplier bundle.
// The arbiter takes the slave side; the environment takes master.
interface mul_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_vld;
  logic [N_REQ*8-1:0] req_a;
  logic [N_REQ*8-1:0] req_b;
  logic [N_REQ-1:0]   req_rdy;
  logic               rsp_vld;
  logic [IW-1:0]      rsp_id;
  logic [15:0]        rsp_res;
  logic               rsp_rdy;
  logic [7:0]         mul_a;
  logic [7:0]         mul_b;
  logic               mul_vld;
  logic [15:0]        mul_res;
  logic               mul_res_rdy;
  logic               busy;

  modport master (
    output req_vld, req_a, req_b, rsp_rdy,
    output mul_res, mul_res_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_res,
    input  mul_a, mul_b, mul_vld, busy
  );

  modport slave (
    input  req_vld, req_a, req_b, rsp_rdy,
    input  mul_res, mul_res_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_res,
    output mul_a, mul_b, mul_vld, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end for a shared sequential 8x8
// multiplier with one transaction in flight at a time.
module mul_arbiter #(
  parameter int N_REQ = 4
) (
  input logic          clk,
  input logic          rst,
  mul_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id;
  logic [IW-1:0] gnt;
  logic [IW-1:0] cand;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [15:0]   res;
  logic          mul_vld;
  logic          rsp_vld;
  logic          hit;

  // Search ptr+1 .. ptr+N_REQ; IW-bit adds wrap for power-of-two N_REQ.
  always_comb begin
    gnt  = ptr;
    hit  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr + IW'(i);
      if (!hit && bus.req_vld[cand]) begin
        gnt = cand;
        hit = 1'b1;
      end
    end
  end

  assign bus.req_rdy =
    (state == IDLE && hit && !rst)
      ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt)
      : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= IW'(N_REQ - 1);
      id      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      mul_vld <= 1'b0;
      rsp_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            op_a    <= bus.req_a[{gnt, 3'b000} +: 8];
            op_b    <= bus.req_b[{gnt, 3'b000} +: 8];
            id      <= gnt;
            ptr     <= gnt;
            mul_vld <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          mul_vld <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (bus.mul_res_rdy) begin
            res     <= bus.mul_res;
            rsp_vld <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            rsp_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_a   = op_a;
  assign bus.mul_b   = op_b;
  assign bus.mul_vld = mul_vld;
  assign bus.rsp_vld = rsp_vld;
  assign bus.rsp_id  = id;
  assign bus.rsp_res = res;
  assign bus.busy    = (state != IDLE);
endmodule
